// File: rtl/spi_pkg.sv
// Shared types and pin idle levels for the SPI mode-0 receive deserializer.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizers reset to these so releasing reset never looks like a pin edge
    localparam logic SCK_IDLE = 1'b0;
    localparam logic CSN_IDLE = 1'b1;
    localparam logic SDI_IDLE = 1'b0;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop pin synchronizer with a delayed copy for rise/fall pulse detection.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 receiver: oversampled pins, MSB-first shift, valid/ready word output
// with frame strobes, partial-word indication and a sticky overrun flag.
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             sdi,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] word_idx,
    output logic             frame_start,
    output logic             frame_end,
    output logic             partial,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [WIDTH-1:0]       r_sr, r_out_data, w_word;
    logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [IDX_W-1:0]       r_word_cnt, r_word_idx;
    logic                   r_out_valid, r_overrun;
    logic                   r_frame_start, r_frame_end, r_partial;
    logic w_sck_rise, w_cs_rise, w_cs_fall, w_sdi_s;
    logic w_unused_sck_level, w_unused_sck_fall, w_unused_cs_level;
    logic w_shift_en, w_word_done, w_load, w_drop;
    logic w_frame_start, w_frame_end, w_partial;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
        .clk(clk), .rst_n(reset), .i_pin(sck),
        .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_unused_sck_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CSN_IDLE)) u_cs_sync (
        .clk(clk), .rst_n(reset), .i_pin(cs_n),
        .o_level(w_unused_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Same depth as the sck/cs_n paths so sdi is aligned with the sck edge it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sdi_sync <= {SYNC_STAGES{SDI_IDLE}};
        else        r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
    end
    assign w_sdi_s = r_sdi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_cs_fall)       w_state_nxt = SHIFT;
        else if (r_state == SHIFT && w_cs_rise) w_state_nxt = IDLE;
    end

    // partial looks at the post-shift count so a coincident sck edge completing a word wins
    always_comb begin
        w_frame_start = (r_state == IDLE) && w_cs_fall;
        w_frame_end   = (r_state == SHIFT) && w_cs_rise;
        w_partial     = w_frame_end && (w_bit_cnt_nxt != '0);
    end

    assign w_shift_en  = (r_state == SHIFT) && w_sck_rise;
    assign w_word_done = w_shift_en && (r_bit_cnt == LAST_BIT);
    assign w_word      = {r_sr[WIDTH-2:0], w_sdi_s};
    assign w_load      = w_word_done && (!r_out_valid || out_ready);
    assign w_drop      = w_word_done && r_out_valid && !out_ready;

    always_comb begin
        w_bit_cnt_nxt = r_bit_cnt;
        if (w_frame_start)   w_bit_cnt_nxt = '0;
        else if (w_shift_en) w_bit_cnt_nxt = w_word_done ? '0 : r_bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_out_data    <= '0;
            r_word_idx    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_partial     <= 1'b0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_partial     <= w_partial;
            if (w_shift_en) r_sr <= w_word;
            if (w_frame_start)
                r_word_cnt <= '0;
            else if (w_word_done && r_word_cnt != '1)
                r_word_cnt <= r_word_cnt + 1'b1;
            if (w_load) begin
                r_out_data <= w_word;
                r_word_idx <= r_word_cnt;
            end
            if (w_load)         r_out_valid <= 1'b1;
            else if (out_ready) r_out_valid <= 1'b0;
            if (w_drop)           r_overrun <= 1'b1;
            else if (clr_overrun) r_overrun <= 1'b0;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign word_idx    = r_word_idx;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign partial     = r_partial;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Randomized bench for spi_rx_deser: pin-level SPI driver, expected-word queue,
// independent monitor popping on every accepted word.
module tb_spi_rx_deser;

    logic       clk = 1'b0, reset = 1'b0;
    logic       sck = 1'b0, cs_n = 1'b1, sdi = 1'b0;
    logic       out_ready = 1'b0, clr_overrun = 1'b0;
    logic [7:0] out_data, word_idx;
    logic       out_valid, frame_start, frame_end, partial, overrun;

    spi_rx_deser #(.WIDTH(8), .SYNC_STAGES(2), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .word_idx(word_idx), .frame_start(frame_start), .frame_end(frame_end),
        .partial(partial), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic [7:0] idx; } exp_t;
    exp_t sb[$];

    int  checks = 0, failures = 0;
    int  fs_cnt = 0, fe_cnt = 0, pt_cnt = 0;
    bit  rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts strobes and checks every accepted word against the queue
    always @(negedge clk) begin
        if (reset) begin
            if (frame_start) fs_cnt++;
            if (frame_end)   fe_cnt++;
            if (partial) begin
                pt_cnt++;
                chk("partial_with_frame_end", frame_end, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {1'b1, out_data}, {1'b0, out_data});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word_data", out_data, e.d);
                    chk("word_idx", word_idx, e.idx);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    // mode 0: plain, 1: pulse out_ready in the cycle the last bit completes, 2: latency check
    task automatic send_bits(input logic [7:0] w, input int n, input int h, input int mode);
        for (int i = 7; i >= 8 - n; i--) begin
            sck = 1'b0;
            sdi = w[i];
            repeat (h) tick();
            sck = 1'b1;
            if (i == 8 - n && mode == 1) begin
                tick(); tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                repeat (h - 3) tick();
            end else if (i == 8 - n && mode == 2) begin
                tick(); tick();
                chk("latency_not_early", out_valid, 1'b0);
                tick();
                chk("latency_valid", out_valid, 1'b1);
                chk("latency_data", out_data, w);
                repeat (h - 3) tick();
            end else begin
                repeat (h) tick();
            end
        end
    endtask

    task automatic cs_start(input int h);
        sck  = 1'b0;
        cs_n = 1'b0;
        repeat (h + 2) tick();
    endtask

    task automatic cs_end(input int h);
        sck = 1'b0;
        repeat (h) tick();
        cs_n = 1'b1;
        repeat (h + 4) tick();
    endtask

    task automatic wait_drain;
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0, p0, nw, tail, h, exp_fe, exp_pt;
        logic [7:0] w;

        repeat (3) tick();
        chk("reset_outputs", {out_data, out_valid, word_idx, frame_start, frame_end, partial, overrun}, 0);
        reset = 1'b1;
        repeat (2) tick();

        // single word with latency check
        out_ready = 1'b1;
        f0 = fs_cnt; e0 = fe_cnt; p0 = pt_cnt;
        cs_start(4);
        chk("t1_frame_start", fs_cnt - f0, 1);
        sb.push_back('{8'hA5, 8'd0});
        send_bits(8'hA5, 8, 4, 2);
        cs_end(4);
        chk("t1_frame_end", fe_cnt - e0, 1);
        chk("t1_no_partial", pt_cnt - p0, 0);
        wait_drain();

        // back-to-back words, always ready
        cs_start(4);
        sb.push_back('{8'h01, 8'd0}); send_bits(8'h01, 8, 4, 0);
        sb.push_back('{8'h80, 8'd1}); send_bits(8'h80, 8, 4, 0);
        sb.push_back('{8'hFF, 8'd2}); send_bits(8'hFF, 8, 4, 0);
        cs_end(4);
        wait_drain();
        chk("t2_no_overrun", overrun, 1'b0);

        // back-pressure: second word dropped, overrun sticky until cleared
        out_ready = 1'b0;
        cs_start(4);
        sb.push_back('{8'h3C, 8'd0}); send_bits(8'h3C, 8, 4, 0);
        send_bits(8'hC3, 8, 4, 0);
        cs_end(4);
        chk("t3_data_held", out_data, 8'h3C);
        chk("t3_valid_held", out_valid, 1'b1);
        chk("t3_overrun_set", overrun, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("t3_valid_dropped", out_valid, 1'b0);
        chk("t3_queue_empty", sb.size(), 0);
        chk("t3_overrun_sticky", overrun, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        tick();
        chk("t3_overrun_cleared", overrun, 1'b0);

        // frame ends after 5 bits, next frame realigns
        out_ready = 1'b1;
        e0 = fe_cnt; p0 = pt_cnt;
        cs_start(4);
        send_bits(8'hE8, 5, 4, 0);
        cs_end(4);
        chk("t4_frame_end", fe_cnt - e0, 1);
        chk("t4_partial", pt_cnt - p0, 1);
        chk("t4_no_valid", out_valid, 1'b0);
        cs_start(4);
        sb.push_back('{8'h5A, 8'd0}); send_bits(8'h5A, 8, 4, 0);
        cs_end(4);
        wait_drain();

        // reset mid-word
        cs_start(4);
        send_bits(8'hF0, 4, 4, 0);
        e0 = fe_cnt;
        reset = 1'b0;
        tick();
        chk("t5_reset_outputs", {out_data, out_valid, word_idx, frame_start, frame_end, partial, overrun}, 0);
        cs_n = 1'b1; sck = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("t5_no_frame_end", fe_cnt - e0, 0);
        cs_start(4);
        sb.push_back('{8'h96, 8'd0}); send_bits(8'h96, 8, 4, 2);
        cs_end(4);
        wait_drain();

        // sck activity with cs_n high is ignored
        out_ready = 1'b0;
        f0 = fs_cnt; e0 = fe_cnt;
        for (int i = 0; i < 16; i++) begin
            sdi = 1'($urandom);
            sck = ~sck;
            repeat (4) tick();
        end
        chk("t6_idle_no_start", fs_cnt - f0, 0);
        chk("t6_idle_no_end", fe_cnt - e0, 0);
        chk("t6_idle_no_valid", out_valid, 1'b0);

        // ready arrives in the same cycle the next word completes
        cs_start(4);
        sb.push_back('{8'h24, 8'd0}); send_bits(8'h24, 8, 4, 0);
        sb.push_back('{8'h42, 8'd1}); send_bits(8'h42, 8, 4, 1);
        chk("t6_new_word_loaded", out_data, 8'h42);
        chk("t6_valid_kept", out_valid, 1'b1);
        chk("t6_no_overrun", overrun, 1'b0);
        cs_end(4);
        out_ready = 1'b1;
        wait_drain();

        // word index saturates at 255
        cs_start(3);
        for (int k = 0; k < 258; k++) begin
            w = 8'($urandom);
            sb.push_back('{w, 8'((k > 255) ? 255 : k)});
            send_bits(w, 8, 3, 0);
        end
        cs_end(3);
        wait_drain();

        // random frames: words = bits/8, partial iff bits%8 != 0
        rnd_ready = 1'b1;
        e0 = fe_cnt; p0 = pt_cnt; exp_fe = 0; exp_pt = 0;
        for (int f = 0; f < 12; f++) begin
            h = $urandom_range(3, 6);
            nw = $urandom_range(0, 4);
            tail = ($urandom_range(1) != 0) ? $urandom_range(1, 7) : 0;
            cs_start(h);
            for (int k = 0; k < nw; k++) begin
                w = 8'($urandom);
                sb.push_back('{w, 8'(k)});
                send_bits(w, 8, h, 0);
            end
            if (tail != 0) send_bits(8'($urandom), tail, h, 0);
            cs_end(h);
            exp_fe++;
            if (tail != 0) exp_pt++;
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("rnd_frame_ends", fe_cnt - e0, exp_fe);
        chk("rnd_partials", pt_cnt - p0, exp_pt);
        chk("rnd_no_overrun", overrun, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
